// File: rtl/cw_msg_keyer_pkg.sv
// Shared definitions for the CW message keyer: symbol codes, FSM states,
// element/gap lengths in Morse units and the unit-length helper.
package cw_pkg;

  // Two-bit symbol codes stored in the message ROM, slot 0 in the LSBs.
  localparam logic [1:0] SYM_END = 2'b00;
  localparam logic [1:0] SYM_DIT = 2'b01;
  localparam logic [1:0] SYM_DAH = 2'b10;
  localparam logic [1:0] SYM_GAP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ELEM_ON,
    ST_ELEM_OFF,
    ST_GAP
  } state_t;

  // Durations in Morse units.
  localparam int unsigned ON_DIT   = 1;
  localparam int unsigned ON_DAH   = 3;
  localparam int unsigned OFF_ELEM = 1;
  localparam int unsigned OFF_CHAR = 2;
  localparam int unsigned OFF_WORD = 6;

  // PARIS timing: one unit lasts 1.2 s / WPM.
  function automatic int unsigned dit_cycles(input int unsigned clk_hz,
                                             input int unsigned wpm);
    return (clk_hz * 6) / (wpm * 5);
  endfunction

endpackage

// File: rtl/cw_msg_keyer_unit_timer.sv
// Morse unit timer: after a start pulse, counts n_units whole units of
// DIT_CYC clocks and raises done for exactly one cycle in the final clock.
module cw_unit_timer #(
  parameter int unsigned DIT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] n_units,
  output logic       done
);

  localparam int unsigned CW = (DIT_CYC > 1) ? $clog2(DIT_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(DIT_CYC - 1);

  logic [CW-1:0] cyc;
  logic [2:0]    unit;
  logic [2:0]    last_unit;
  logic          active;

  assign done = active && (cyc == CYC_LAST) && (unit == last_unit);

  // Cycle and unit counters; a start restarts the count even on a done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc       <= '0;
      unit      <= '0;
      last_unit <= '0;
      active    <= 1'b0;
    end else if (start) begin
      cyc       <= '0;
      unit      <= '0;
      last_unit <= n_units - 3'd1;
      active    <= 1'b1;
    end else if (active) begin
      if (cyc == CYC_LAST) begin
        cyc <= '0;
        if (unit == last_unit) begin
          active <= 1'b0;
        end else begin
          unit <= unit + 3'd1;
        end
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cw_msg_keyer.sv
// Parametrised Morse message keyer. Request edges are captured into a
// pending bitmap, pushed lowest-index first into a small circular FIFO,
// and the FSM keys each queued ROM message. BEACON repeats BEACON_IDX when
// nothing is queued. Optional sidetone: define CW_MSG_KEYER_SIDETONE_EN.
module cw_msg_keyer
  import cw_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned WPM         = 20,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned MSG_LEN     = 16,
  parameter logic [N_REQ*MSG_LEN*2-1:0] MSG_ROM = '0,
  parameter int unsigned BEACON_IDX  = 0,
  parameter int unsigned TONE_HZ     = 700
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_REQ-1:0]             REQ,
  input  logic                         BEACON,
  output logic                         KEY_OUT,
  output logic                         TONE,
  output logic                         BUSY,
  output logic [$clog2(N_REQ)-1:0]     CUR_IDX,
  output logic [$clog2(QUEUE_DEPTH):0] Q_COUNT
);

  localparam int unsigned DIT_CYC = dit_cycles(CLK_HZ, WPM);
  localparam int unsigned IW      = $clog2(N_REQ);
  localparam int unsigned AW      = $clog2(QUEUE_DEPTH);
  localparam int unsigned SW      = $clog2(MSG_LEN);
  localparam logic [SW-1:0] LAST_SLOT = SW'(MSG_LEN - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(QUEUE_DEPTH);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
      MSG_LEN < 2 || N_REQ < 2 || BEACON_IDX >= N_REQ || TONE_HZ == 0 ||
      DIT_CYC == 0) begin : g_cfg_check
    $error("cw_msg_keyer: invalid parameter set");
  end

  function automatic logic [1:0] rom_sym(input logic [IW-1:0] idx,
                                         input logic [SW-1:0] slot);
    int unsigned base;
    base = (32'(idx) * MSG_LEN + 32'(slot)) * 2;
    return MSG_ROM[base +: 2];
  endfunction

  // Request capture and FIFO
  logic [N_REQ-1:0] req_prev;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] queued;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] push_mask;
  logic [IW-1:0]    push_idx;
  logic             have_pend;
  logic             push;
  logic             pop;
  logic [IW-1:0]    fifo_mem [QUEUE_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [IW-1:0]    fifo_head;

  // FSM
  state_t        state, state_n;
  logic [SW-1:0] sym_idx, sym_n;
  logic [IW-1:0] cur_idx, cur_n;
  logic          final_gap, final_n;
  logic          advance;
  logic          decode;
  logic [SW-1:0] dec_slot;
  logic [1:0]    dec_sym;
  logic          tmr_start;
  logic [2:0]    tmr_units;
  logic          tmr_done;
  logic          key_on;

  assign rise       = REQ & ~req_prev;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign push       = have_pend && !fifo_full;

  // Lowest pending index wins the single push slot each cycle.
  always_comb begin
    push_idx  = '0;
    have_pend = 1'b0;
    push_mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pending[i] && !have_pend) begin
        have_pend = 1'b1;
        push_idx  = IW'(i);
      end
    end
    if (push) begin
      push_mask[push_idx] = 1'b1;
    end
  end

  // Edge history, pending bitmap, in-FIFO bitmap and FIFO pointers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_prev <= '0;
      pending  <= '0;
      queued   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      req_prev <= REQ;
      // Edges on an index already pending or already queued are merged.
      pending  <= (pending & ~push_mask) | (rise & ~pending & ~queued);
      if (pop) begin
        queued[fifo_head] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        queued[push_idx] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_idx;
    end
  end

  // FSM state and message position registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      sym_idx   <= '0;
      cur_idx   <= '0;
      final_gap <= 1'b0;
    end else begin
      state     <= state_n;
      sym_idx   <= sym_n;
      cur_idx   <= cur_n;
      final_gap <= final_n;
    end
  end

  // Next-state logic; finishing an element or gap decodes the next slot in
  // the same cycle so every state lasts an exact number of units.
  always_comb begin
    state_n   = state;
    sym_n     = sym_idx;
    cur_n     = cur_idx;
    final_n   = final_gap;
    pop       = 1'b0;
    tmr_start = 1'b0;
    tmr_units = '0;
    advance   = 1'b0;
    decode    = 1'b0;
    dec_slot  = sym_idx;
    dec_sym   = SYM_END;

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_n   = fifo_head;
          state_n = ST_LOAD;
        end else if (BEACON) begin
          cur_n   = IW'(BEACON_IDX);
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        decode   = 1'b1;
        dec_slot = '0;
      end
      ST_ELEM_ON: begin
        if (tmr_done) begin
          state_n   = ST_ELEM_OFF;
          tmr_start = 1'b1;
          tmr_units = 3'(OFF_ELEM);
        end
      end
      ST_ELEM_OFF: begin
        if (tmr_done) begin
          advance = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          if (final_gap) begin
            state_n = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (advance) begin
      if (sym_idx == LAST_SLOT) begin
        // Running past the last slot closes the message like END.
        state_n   = ST_GAP;
        final_n   = 1'b1;
        tmr_start = 1'b1;
        tmr_units = 3'(OFF_WORD);
      end else begin
        decode   = 1'b1;
        dec_slot = sym_idx + 1'b1;
      end
    end

    if (decode) begin
      dec_sym = rom_sym(cur_idx, dec_slot);
      sym_n   = dec_slot;
      case (dec_sym)
        SYM_DIT: begin
          state_n   = ST_ELEM_ON;
          final_n   = 1'b0;
          tmr_start = 1'b1;
          tmr_units = 3'(ON_DIT);
        end
        SYM_DAH: begin
          state_n   = ST_ELEM_ON;
          final_n   = 1'b0;
          tmr_start = 1'b1;
          tmr_units = 3'(ON_DAH);
        end
        SYM_GAP: begin
          state_n   = ST_GAP;
          final_n   = 1'b0;
          tmr_start = 1'b1;
          tmr_units = 3'(OFF_CHAR);
        end
        default: begin
          if (dec_slot == '0) begin
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_GAP;
            final_n   = 1'b1;
            tmr_start = 1'b1;
            tmr_units = 3'(OFF_WORD);
          end
        end
      endcase
    end
  end

  cw_unit_timer #(
    .DIT_CYC(DIT_CYC)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .start  (tmr_start),
    .n_units(tmr_units),
    .done   (tmr_done)
  );

  assign key_on  = (state == ST_ELEM_ON);
  assign KEY_OUT = key_on;
  assign BUSY    = (state != ST_IDLE);
  assign CUR_IDX = cur_idx;
  assign Q_COUNT = count;

`ifdef CW_MSG_KEYER_SIDETONE_EN
  localparam int unsigned TONE_RAW = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned TONE_DIV = (TONE_RAW > 0) ? TONE_RAW : 1;
  localparam int unsigned TW       = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] tone_cnt;
  logic          tone_q;

  // Sidetone divider, held cleared whenever the key is up.
  always_ff @(posedge CLK) begin
    if (RST || !key_on) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      tone_q   <= ~tone_q;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign TONE = tone_q & key_on;
`else
  assign TONE = 1'b0;
`endif

endmodule

// File: tb/tb_cw_msg_keyer.sv
// Scoreboard bench for cw_msg_keyer: each scenario pushes the expected output
// changes (cycle, KEY_OUT, BUSY, CUR_IDX, Q_COUNT) and a monitor pops one
// entry whenever the DUT outputs change. DIT_CYC = 1000*6/(12*5) = 100.
module tb_cw_msg_keyer;

  localparam logic [127:0] ROM = {32'h0000_0001,   // msg3: DIT END
                                  32'h0000_0001,   // msg2: DIT END
                                  32'h0000_001E,   // msg1: DAH GAP DIT END
                                  32'h0000_0001};  // msg0: DIT END

  typedef struct {
    int         cyc;
    logic       key;
    logic       busy;
    logic [1:0] idx;
    logic [1:0] qc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       beacon = 1'b0;
  logic       key_out, tone, busy;
  logic [1:0] cur_idx;
  logic [1:0] q_count;

  int   cnt = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  logic [6:0] prev = '0;
  ev_t  exp_q[$];

  cw_msg_keyer #(
    .CLK_HZ     (1000),
    .WPM        (12),
    .N_REQ      (4),
    .QUEUE_DEPTH(2),
    .MSG_LEN    (16),
    .MSG_ROM    (ROM),
    .BEACON_IDX (0),
    .TONE_HZ    (100)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ    (req),
    .BEACON (beacon),
    .KEY_OUT(key_out),
    .TONE   (tone),
    .BUSY   (busy),
    .CUR_IDX(cur_idx),
    .Q_COUNT(q_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  // Monitor: every change on the outputs consumes one expected event.
  always @(negedge clk) begin
    logic [6:0] now;
    ev_t        e;
    now = {tone, key_out, busy, cur_idx, q_count};
    if (mon_on && now !== prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ev_unexpected: cycle %0d got tone=%0b key=%0b busy=%0b idx=%0d q=%0d, required no change",
                 cnt, tone, key_out, busy, cur_idx, q_count);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cnt || tone !== 1'b0 || key_out !== e.key || busy !== e.busy ||
            cur_idx !== e.idx || q_count !== e.qc) begin
          bad++;
          $display("FAIL ev_compare: got cycle=%0d tone=%0b key=%0b busy=%0b idx=%0d q=%0d, required cycle=%0d tone=0 key=%0b busy=%0b idx=%0d q=%0d",
                   cnt, tone, key_out, busy, cur_idx, q_count, e.cyc, e.key, e.busy, e.idx, e.qc);
        end
      end
    end
    prev = now;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic ev(input int c, input logic k, input logic b,
                    input logic [1:0] i, input logic [1:0] q);
    ev_t e;
    e.cyc = c; e.key = k; e.busy = b; e.idx = i; e.qc = q;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int k);
    while (cnt < k) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected events still queued, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    check("rst_key", int'(key_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(cur_idx), 0);
    check("rst_qcount", int'(q_count), 0);
    check("rst_tone", int'(tone), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);

    // 1: single DIT message; on t+4..t+103, BUSY low from t+804.
    c = cnt;
    ev(c + 2, 0, 0, 0, 1); ev(c + 3, 0, 1, 0, 0); ev(c + 4, 1, 1, 0, 0);
    ev(c + 104, 0, 1, 0, 0); ev(c + 804, 0, 0, 0, 0);
    req = 4'b0001;
    wait_cyc(c + 10); req = '0;
    wait_drain(1500, "t1");

    // 2: REQ[1:0] together; msg0 then msg1 (DAH 300, off 100, gap 200, DIT 100).
    @(negedge clk); c = cnt;
    ev(c + 2, 0, 0, 0, 1); ev(c + 3, 0, 1, 0, 1); ev(c + 4, 1, 1, 0, 1);
    ev(c + 104, 0, 1, 0, 1); ev(c + 804, 0, 0, 0, 1); ev(c + 805, 0, 1, 1, 0);
    ev(c + 806, 1, 1, 1, 0); ev(c + 1106, 0, 1, 1, 0); ev(c + 1406, 1, 1, 1, 0);
    ev(c + 1506, 0, 1, 1, 0); ev(c + 2206, 0, 0, 1, 0);
    req = 4'b0011;
    wait_cyc(c + 10); req = '0;
    wait_drain(3000, "t2");

    // 3: REQ[2] rises twice during msg1; merged, keyed once afterwards.
    @(negedge clk); c = cnt;
    ev(c + 2, 0, 0, 1, 1); ev(c + 3, 0, 1, 1, 0); ev(c + 4, 1, 1, 1, 0);
    ev(c + 52, 1, 1, 1, 1); ev(c + 304, 0, 1, 1, 1); ev(c + 604, 1, 1, 1, 1);
    ev(c + 704, 0, 1, 1, 1); ev(c + 1404, 0, 0, 1, 1); ev(c + 1405, 0, 1, 2, 0);
    ev(c + 1406, 1, 1, 2, 0); ev(c + 1506, 0, 1, 2, 0); ev(c + 2206, 0, 0, 2, 0);
    req = 4'b0010;
    wait_cyc(c + 10); req = '0;
    wait_cyc(c + 50); req = 4'b0100;
    wait_cyc(c + 60); req = '0;
    wait_cyc(c + 70); req = 4'b0100;
    wait_cyc(c + 80); req = '0;
    wait_drain(3000, "t3");

    // 4: REQ[3:1] during msg0; FIFO full at 2, index 3 held then played last.
    @(negedge clk); c = cnt;
    ev(c + 2, 0, 0, 2, 1); ev(c + 3, 0, 1, 0, 0); ev(c + 4, 1, 1, 0, 0);
    ev(c + 22, 1, 1, 0, 1); ev(c + 23, 1, 1, 0, 2); ev(c + 104, 0, 1, 0, 2);
    ev(c + 804, 0, 0, 0, 2); ev(c + 805, 0, 1, 1, 1); ev(c + 806, 1, 1, 1, 2);
    ev(c + 1106, 0, 1, 1, 2); ev(c + 1406, 1, 1, 1, 2); ev(c + 1506, 0, 1, 1, 2);
    ev(c + 2206, 0, 0, 1, 2); ev(c + 2207, 0, 1, 2, 1); ev(c + 2208, 1, 1, 2, 1);
    ev(c + 2308, 0, 1, 2, 1); ev(c + 3008, 0, 0, 2, 1); ev(c + 3009, 0, 1, 3, 0);
    ev(c + 3010, 1, 1, 3, 0); ev(c + 3110, 0, 1, 3, 0); ev(c + 3810, 0, 0, 3, 0);
    req = 4'b0001;
    wait_cyc(c + 10); req = '0;
    wait_cyc(c + 20); req = 4'b1110;
    wait_cyc(c + 30); req = '0;
    wait_drain(4500, "t4");

    // 5: beacon repeats msg0; REQ[1] mid-beacon plays next, then beacon resumes.
    @(negedge clk); c = cnt;
    ev(c + 1, 0, 1, 0, 0); ev(c + 2, 1, 1, 0, 0); ev(c + 52, 1, 1, 0, 1);
    ev(c + 102, 0, 1, 0, 1); ev(c + 802, 0, 0, 0, 1); ev(c + 803, 0, 1, 1, 0);
    ev(c + 804, 1, 1, 1, 0); ev(c + 1104, 0, 1, 1, 0); ev(c + 1404, 1, 1, 1, 0);
    ev(c + 1504, 0, 1, 1, 0); ev(c + 2204, 0, 0, 1, 0); ev(c + 2205, 0, 1, 0, 0);
    ev(c + 2206, 1, 1, 0, 0); ev(c + 2306, 0, 1, 0, 0); ev(c + 3006, 0, 0, 0, 0);
    beacon = 1'b1;
    wait_cyc(c + 50); req = 4'b0010;
    wait_cyc(c + 60); req = '0;
    wait_cyc(c + 2400); beacon = 1'b0;
    wait_drain(1500, "t5");

    // 6: reset mid-DAH clears key, busy, index and queue; nothing follows.
    @(negedge clk); c = cnt;
    ev(c + 2, 0, 0, 0, 1); ev(c + 3, 0, 1, 1, 0); ev(c + 4, 1, 1, 1, 0);
    ev(c + 22, 1, 1, 1, 1); ev(c + 101, 0, 0, 0, 0);
    req = 4'b0010;
    wait_cyc(c + 10); req = '0;
    wait_cyc(c + 20); req = 4'b0100;
    wait_cyc(c + 30); req = '0;
    wait_cyc(c + 100); rst = 1'b1;
    wait_cyc(c + 101); rst = 1'b0;
    wait_drain(500, "t6");
    repeat (1000) @(negedge clk);
    check("t6_idle_key", int'(key_out), 0);
    check("t6_idle_busy", int'(busy), 0);
    check("t6_idle_qcount", int'(q_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
